vec_lane_sequencer: RTL

- Execute-stage front end of the vector pipeline, sitting directly upstream of the scalar ALU.
- Accepts one vector instruction (opcode plus two LANES-wide operand vectors) over a valid/ready handshake.
- Walks the lanes one per cycle through the single shared combinational ALU and assembles the result vector and aggregate flags.
- Presents the completed result to the memory/writeback stage over a second valid/ready handshake.

---
 rtl/vec_lane_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vec_lane_sequencer.sv
// Purpose : serialises one LANES-wide vector instruction through a single shared scalar ALU, one lane per cycle.
// Latency : accept at edge E0 -> out_valid after edge E_LANES; a nop completes after edge E1.
// Backpressure: a completed result is held stable in DONE until out_ready; no new instruction is taken meanwhile.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid/in_ready         instruction handshake; in_op, in_vec_a, in_vec_b carry the instruction
//   in_broadcast              (only with VEC_SCALAR_BROADCAST_EN) replicate lane 0 of B into every B lane
//   alu_op/alu_a/alu_b        drive to the combinational ALU; alu_result/alu_neg/alu_zero return same cycle
//   out_valid/out_ready       result handshake; out_vec plus aggregate out_neg (OR) and out_zero (AND)
//
// Optional feature macro: VEC_SCALAR_BROADCAST_EN (undefined by default -> element-wise only).

module vec_lane_sequencer #(
    parameter int dataSize = 8,
    parameter int LANES    = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_op,
    input  logic [LANES*dataSize-1:0]   in_vec_a,
    input  logic [LANES*dataSize-1:0]   in_vec_b,
`ifdef VEC_SCALAR_BROADCAST_EN
    input  logic                        in_broadcast,
`endif

    output logic [2:0]                  alu_op,
    output logic [dataSize-1:0]         alu_a,
    output logic [dataSize-1:0]         alu_b,
    input  logic [dataSize-1:0]         alu_result,
    input  logic                        alu_neg,
    input  logic                        alu_zero,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*dataSize-1:0]   out_vec,
    output logic                        out_neg,
    output logic                        out_zero
);

    localparam int IDX_W = (LANES > 2) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_NOP = 3'b000;

    logic [1:0]                 state;
    logic [IDX_W-1:0]           idx;
    logic [2:0]                 op_q;
    logic [LANES*dataSize-1:0]  vec_a_q;
    logic [LANES*dataSize-1:0]  vec_b_q;
    logic [LANES*dataSize-1:0]  res_q;
    logic                       neg_q;
    logic                       zero_q;
    logic                       valid_q;

    logic                       accept;
    logic [LANES*dataSize-1:0]  b_accept;

    assign in_ready  = (state == S_IDLE);
    assign accept    = in_valid && in_ready;

    assign out_valid = valid_q;
    assign out_vec   = res_q;
    assign out_neg   = neg_q;
    assign out_zero  = zero_q;

    // B operand as it will be latched; broadcast turns lane 0 into a scalar.
    always_comb begin
        b_accept = in_vec_b;
`ifdef VEC_SCALAR_BROADCAST_EN
        if (in_broadcast) begin
            for (int i = 0; i < LANES; i++) begin
                b_accept[i*dataSize +: dataSize] = in_vec_b[dataSize-1:0];
            end
        end
`endif
    end

    // ALU sees the current lane only while executing; otherwise it is parked on nop/0/0.
    always_comb begin
        alu_op = OP_NOP;
        alu_a  = '0;
        alu_b  = '0;
        if (state == S_EXEC) begin
            alu_op = op_q;
            alu_a  = vec_a_q[int'(idx)*dataSize +: dataSize];
            alu_b  = vec_b_q[int'(idx)*dataSize +: dataSize];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            op_q    <= OP_NOP;
            vec_a_q <= '0;
            vec_b_q <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= in_op;
                        vec_a_q <= in_vec_a;
                        vec_b_q <= b_accept;
                        idx     <= '0;
                        res_q   <= '0;
                        neg_q   <= 1'b0;
                        zero_q  <= 1'b1;
                        // A nop has nothing to compute: its all-zero result is
                        // already in place, so skip the lane walk entirely.
                        state   <= (in_op == OP_NOP) ? S_DONE : S_EXEC;
                    end
                end

                S_EXEC: begin
                    res_q[int'(idx)*dataSize +: dataSize] <= alu_result;
                    neg_q  <= neg_q | alu_neg;
                    zero_q <= zero_q & alu_zero;
                    if (idx == LAST_IDX) begin
                        // Index returns to 0 so it never leaves the lane range.
                        idx     <= '0;
                        valid_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                S_DONE: begin
                    // Arriving from a nop, out_valid is raised one edge after
                    // accept, matching the single-pass timing of a lane op.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
